// File: rtl/decode_queue.sv
// decode_queue
//   Instruction queue between fetch (IF) and decode (ID). It holds DEPTH
//   entries and uses valid/ready handshakes on both sides. Register indices,
//   the SYSTEM flag and RV32I legality are pre-decoded when an entry is
//   enqueued and are stored with it. The head outputs therefore come straight
//   from registered storage. Fetch can run ahead while decode is stalled.
//
// Parameters
//   DEPTH       number of entries (power of two, >= 2)
//   PC_W        program-counter width
//   ENABLE_CSR  1: SYSTEM opcode is legal and is echoed on out_csr_inst
//               0: SYSTEM opcode is flagged invalid
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   flush          synchronous; drops every entry and any same-cycle push
//   in_valid/in_ready/in_inst/in_pc        enqueue side
//   out_valid/out_ready/out_inst/out_pc    head entry / dequeue side
//   out_rs1/out_rs2/out_rd                 pre-decoded register indices
//   out_csr_inst   head instruction when it is a SYSTEM opcode, else 0
//   out_is_system  head opcode == 1110011
//   out_invalid    head is not a legal RV32I instruction
//   count          occupancy

module decode_queue #(
  parameter int DEPTH      = 4,
  parameter int PC_W       = 32,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst,
  output logic [PC_W-1:0]              out_pc,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [31:0]                  out_csr_inst,
  output logic                         out_is_system,
  output logic                         out_invalid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        is_system;
    logic        invalid;
  } entry_t;

  entry_t                 mem    [DEPTH];
  logic [PC_W-1:0]        pc_mem [DEPTH];

  logic [PTR_W-1:0]       wptr;
  logic [PTR_W-1:0]       rptr;
  logic [CNT_W-1:0]       cnt_q;

  logic                   push;
  logic                   pop;
  entry_t                 dec;
  entry_t                 head;

  // ---------------------------------------------------------------------------
  // Handshakes. in_ready looks only at the registered count, so a full queue
  // refuses a push even while the head is being popped in the same cycle.
  // ---------------------------------------------------------------------------
  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = cnt_q;

  // ---------------------------------------------------------------------------
  // Enqueue-time pre-decode
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    opcode = in_inst[6:0];
    funct3 = in_inst[14:12];
    funct7 = in_inst[31:25];
    legal  = 1'b0;

    dec           = '0;
    dec.inst      = in_inst;
    dec.rs1       = in_inst[19:15];
    dec.rs2       = in_inst[24:20];
    dec.rd        = in_inst[11:7];
    dec.is_system = 1'b0;

    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        dec.rs1 = '0;
        dec.rs2 = '0;
        legal   = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.rs2 = '0;
        // Only the shift-immediates constrain funct7; the shamt occupies the
        // low bits of the immediate, so the upper bits must be a valid funct7.
        if (funct3 == 3'b001)
          legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101)
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else
          legal = 1'b1;
      end
      OPC_LOAD: begin
        dec.rs2 = '0;
        legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OPC_JALR: begin
        dec.rs2 = '0;
        legal   = (funct3 == 3'b000);
      end
      OPC_STORE: begin
        dec.rd = '0;
        legal  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OPC_BRANCH: begin
        dec.rd = '0;
        legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_OP: begin
        // funct7 0100000 exists only for SUB and SRA.
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_SYSTEM: begin
        dec.rs2       = '0;
        dec.is_system = 1'b1;
        legal         = ENABLE_CSR;
      end
      default: legal = 1'b0;
    endcase

    dec.invalid = !legal;
  end

  // ---------------------------------------------------------------------------
  // Storage. Payload is not reset; the count gates every head output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr]    <= dec;
      pc_mem[wptr] <= in_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation. An empty queue shows a NOP with every other field 0.
  // ---------------------------------------------------------------------------
  assign head = mem[rptr];

  always_comb begin
    out_inst      = NOP_INST;
    out_pc        = '0;
    out_rs1       = '0;
    out_rs2       = '0;
    out_rd        = '0;
    out_csr_inst  = '0;
    out_is_system = 1'b0;
    out_invalid   = 1'b0;
    if (out_valid) begin
      out_inst      = head.inst;
      out_pc        = pc_mem[rptr];
      out_rs1       = head.rs1;
      out_rs2       = head.rs2;
      out_rd        = head.rd;
      out_is_system = head.is_system;
      out_invalid   = head.invalid;
      out_csr_inst  = (head.is_system && ENABLE_CSR) ? head.inst : '0;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue
//   Directed bench for decode_queue. The stimulus pushes the hand-computed
//   expected entry for every accepted enqueue. A monitor compares the head
//   against that queue on every dequeue handshake. A second instance built
//   with ENABLE_CSR=0 shares all the inputs, and its legality flag is
//   compared on the same dequeues.

module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int NV    = 14;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [PC_W-1:0]   out_pc;
  logic [4:0]        out_rs1, out_rs2, out_rd;
  logic [31:0]       out_csr_inst;
  logic              out_is_system;
  logic              out_invalid;
  logic [CNT_W-1:0]  count;

  logic              n_in_ready, n_out_valid, n_out_is_system, n_out_invalid;
  logic [31:0]       n_out_inst, n_out_csr_inst;
  logic [PC_W-1:0]   n_out_pc;
  logic [4:0]        n_out_rs1, n_out_rs2, n_out_rd;
  logic [CNT_W-1:0]  n_count;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .ENABLE_CSR(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_csr_inst(out_csr_inst), .out_is_system(out_is_system),
    .out_invalid(out_invalid), .count(count)
  );

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .ENABLE_CSR(1'b0)) u_nocsr (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_inst(n_out_inst), .out_pc(n_out_pc),
    .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_rd(n_out_rd),
    .out_csr_inst(n_out_csr_inst), .out_is_system(n_out_is_system),
    .out_invalid(n_out_invalid), .count(n_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        sys;
    logic        inv;
  } vec_t;

  typedef struct {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1, rs2, rd;
    logic [31:0]     csr;
    logic            sys, inv, inv_nocsr;
  } exp_t;

  vec_t vt [NV];
  exp_t sb [$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Dequeue monitor
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got pc %h expected no entry", out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pc",        out_pc,        e.pc);
        chk("inst",      out_inst,      e.inst);
        chk("rs1",       32'(out_rs1),  32'(e.rs1));
        chk("rs2",       32'(out_rs2),  32'(e.rs2));
        chk("rd",        32'(out_rd),   32'(e.rd));
        chk("csr_inst",  out_csr_inst,  e.csr);
        chk("is_system", 32'(out_is_system), 32'(e.sys));
        chk("invalid",   32'(out_invalid),   32'(e.inv));
        chk("nocsr_invalid", 32'(n_out_invalid), 32'(e.inv_nocsr));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and hold it until it is accepted. in_valid stays high on
  // return so consecutive pushes are back-to-back; stop_push ends a burst.
  task automatic push_vec(input int idx, input logic [PC_W-1:0] pc);
    bit   ok;
    exp_t e;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_inst  = vt[idx].inst;
    in_pc    = pc;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      e.inst      = vt[idx].inst;
      e.pc        = pc;
      e.rs1       = vt[idx].rs1;
      e.rs2       = vt[idx].rs2;
      e.rd        = vt[idx].rd;
      e.sys       = vt[idx].sys;
      e.inv       = vt[idx].inv;
      e.inv_nocsr = vt[idx].inv | vt[idx].sys;
      e.csr       = vt[idx].sys ? vt[idx].inst : 32'h0;
      sb.push_back(e);
      step();
    end else begin
      total++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 within 64 cycles");
    end
  endtask

  task automatic stop_push();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 100; n++) begin
      if (count == '0) break;
      step();
    end
    chk("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    vt[0]  = '{32'h3000_2573, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0}; // csrrs a0,mstatus
    vt[1]  = '{32'h1234_50B7, 5'd0, 5'd0, 5'd1,  1'b0, 1'b0}; // lui x1
    vt[2]  = '{32'h0011_2623, 5'd2, 5'd1, 5'd0,  1'b0, 1'b0}; // sw x1,12(x2)
    vt[3]  = '{32'h0000_007F, 5'd0, 5'd0, 5'd0,  1'b0, 1'b1}; // bad opcode
    vt[4]  = '{32'h4000_1033, 5'd0, 5'd0, 5'd0,  1'b0, 1'b1}; // OP f7=0100000 f3=001
    vt[5]  = '{32'h0020_81B3, 5'd1, 5'd2, 5'd3,  1'b0, 1'b0}; // add x3,x1,x2
    vt[6]  = '{32'h0073_0293, 5'd6, 5'd0, 5'd5,  1'b0, 1'b0}; // addi x5,x6,7
    vt[7]  = '{32'h4000_5033, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0}; // sra x0,x0,x0
    vt[8]  = '{32'h4000_1013, 5'd0, 5'd0, 5'd0,  1'b0, 1'b1}; // slli with funct7 0100000
    vt[9]  = '{32'h0000_3003, 5'd0, 5'd0, 5'd0,  1'b0, 1'b1}; // load funct3 011
    vt[10] = '{32'h0020_8463, 5'd1, 5'd2, 5'd0,  1'b0, 1'b0}; // beq x1,x2
    vt[11] = '{32'h0000_9067, 5'd1, 5'd0, 5'd0,  1'b0, 1'b1}; // jalr funct3 001
    vt[12] = '{32'h0080_00EF, 5'd0, 5'd0, 5'd1,  1'b0, 1'b0}; // jal x1
    vt[13] = '{32'h0000_0013, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0}; // nop

    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = 32'h0;
    in_pc     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Reset / idle state
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst",  out_inst,       32'h0000_0013);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_pc",    out_pc,         32'h0);
    chk("rst_invalid",   32'(out_invalid), 32'd0);

    // Three fill/drain rounds; pointers wrap each round
    for (int r = 0; r < 3; r++) begin
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++)
        push_vec(r*DEPTH + i, 32'h1000 + 32'((r*DEPTH + i) * 4));
      stop_push();
      chk("full_count",    32'(count),    32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      wait_empty();
    end
    out_ready = 1'b0;

    // Full queue, fifth entry held upstream, then pop-only and push+pop cycles
    push_vec(10, 32'h3000);
    push_vec(11, 32'h3004);
    push_vec(12, 32'h3008);
    push_vec(13, 32'h300C);
    fork
      push_vec(0, 32'h3010);
      begin
        step();
        chk("held_count",    32'(count),    32'd4);
        chk("held_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("pop_only_count",    32'(count),    32'd3);
        chk("pop_only_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("push_pop_count", 32'(count), 32'd3);
      end
    join
    stop_push();
    wait_empty();
    out_ready = 1'b0;

    // Flush with three entries queued and a push in the same cycle
    push_vec(1, 32'h4000);
    push_vec(2, 32'h4004);
    push_vec(3, 32'h4008);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h00A0_0093;
    in_pc    = 32'h4DEAD;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_count",     32'(count),     32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_inst",  out_inst,       32'h0000_0013);
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    push_vec(4, 32'h5000);
    stop_push();
    chk("post_flush_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    wait_empty();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a burst
    push_vec(5, 32'h6000);
    push_vec(6, 32'h6004);
    stop_push();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_inst",  out_inst,       32'h0000_0013);
    chk("arst_count",     32'(count),     32'd0);
    chk("arst_out_rd",    32'(out_rd),    32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_arst_out_valid", 32'(out_valid), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
